// File: rtl/eforth_inner_p.sv
// eForth inner interpreter: fetches byte opcodes and little-endian inline
// arguments over a 1-cycle-latency memory port, with private data and return stacks.
module eforth_inner_p #(
    parameter int DSZ    = 32,
    parameter int ASZ    = 17,
    parameter int DDEPTH = 16,
    parameter int RDEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [ASZ-1:0]                pfa,
    output logic [ASZ-1:0]                mem_addr,
    output logic                          mem_re,
    input  logic [7:0]                    mem_rdata,
    output logic                          bsy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code,
    output logic [DSZ-1:0]                tos,
    output logic [$clog2(DDEPTH+1)-1:0]   sp,
    output logic [2:0]                    dbg_state
);
    localparam int LB  = DSZ / 8;
    localparam int AB  = (ASZ + 7) / 8;
    localparam int MB  = (LB > AB) ? LB : AB;
    localparam int AW  = 8 * MB;
    localparam int SPW = $clog2(DDEPTH + 1);
    localparam int RPW = $clog2(RDEPTH + 1);
    localparam int DIW = $clog2(DDEPTH);
    localparam int RIW = $clog2(RDEPTH);

    localparam logic [SPW-1:0] SP_FULL  = SPW'(DDEPTH);
    localparam logic [SPW-1:0] SP1      = SPW'(1);
    localparam logic [SPW-1:0] SP2      = SPW'(2);
    localparam logic [RPW-1:0] RP_FULL  = RPW'(RDEPTH);
    localparam logic [RPW-1:0] RP1      = RPW'(1);
    localparam logic [ASZ-1:0] IP1      = ASZ'(1);
    localparam logic [ASZ-1:0] IP2      = ASZ'(2);
    localparam logic [ASZ-1:0] IP_LIT   = ASZ'(1 + LB);
    localparam logic [ASZ-1:0] IP_BR    = ASZ'(1 + AB);
    localparam logic [3:0]     LAST_LIT = 4'(LB - 1);
    localparam logic [3:0]     LAST_BR  = 4'(AB - 1);
    localparam logic [DSZ-1:0] D_ONE    = DSZ'(1);

    localparam logic [7:0] OP_NOP = 8'h00, OP_DOLIT = 8'h01, OP_BRAN = 8'h02, OP_ZBRAN = 8'h03;
    localparam logic [7:0] OP_DONEXT = 8'h04, OP_TOR = 8'h05, OP_FROMR = 8'h06, OP_DUP = 8'h07;
    localparam logic [7:0] OP_DROP = 8'h08, OP_OVER = 8'h09, OP_SWAP = 8'h0A, OP_ADD = 8'h0B;
    localparam logic [7:0] OP_SUB = 8'h0C, OP_AND = 8'h0D, OP_OR = 8'h0E, OP_XOR = 8'h0F;
    localparam logic [7:0] OP_ZEQ = 8'h10, OP_ZLT = 8'h11, OP_NEG = 8'h12, OP_EXIT = 8'h13;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_ARG, S_DONE, S_ERR} state_t;

    state_t           state, state_n;
    logic [ASZ-1:0]   ip, ip_n, arg_ip, rtop_ip;
    logic [RPW-1:0]   rsp, rsp_n;
    logic [SPW-1:0]   sp_n;
    logic [7:0]       op_r, cur_op;
    logic [3:0]       cnt;
    logic [AW-1:0]    arg_r, arg_full;
    logic [1:0]       code_r, fault, need_d;
    logic             push_d, need_r, push_r, legal, arg_op, last, apply;
    logic [DSZ-1:0]   dstk [2**DIW];
    logic [DSZ-1:0]   rstk [2**RIW];
    logic [DIW-1:0]   di_top, di_s0, di_new, dwa_a, dwa_b;
    logic [RIW-1:0]   ri_top, ri_new, rwa;
    logic [DSZ-1:0]   tos_v, s0, rtop, dwd_a, dwd_b, rwd;
    logic             dwe_a, dwe_b, rwe;

    assign di_top = DIW'(sp - SP1);
    assign di_s0  = DIW'(sp - SP2);
    assign di_new = DIW'(sp);
    assign ri_top = RIW'(rsp - RP1);
    assign ri_new = RIW'(rsp);
    assign tos_v  = dstk[di_top];
    assign s0     = dstk[di_s0];
    assign rtop   = rstk[ri_top];

    assign tos       = (sp == '0) ? '0 : tos_v;
    assign bsy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_ARG);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign err_code  = code_r;
    assign dbg_state = state;

    // In ARG the opcode comes from the latch; in EXEC it is straight off the bus.
    assign cur_op   = (state == S_ARG) ? op_r : mem_rdata;
    assign arg_full = arg_r | (AW'(mem_rdata) << {cnt, 3'b000});
    assign arg_ip   = arg_full[ASZ-1:0];
    assign last     = (cnt == ((op_r == OP_DOLIT) ? LAST_LIT : LAST_BR));

    always_comb begin
        rtop_ip = '0;
        for (int i = 0; i < ASZ && i < DSZ; i++) rtop_ip[i] = rtop[i];
    end

    // Operand requirements per opcode; faults are raised before anything changes.
    always_comb begin
        need_d = 2'd0;
        push_d = 1'b0;
        need_r = 1'b0;
        push_r = 1'b0;
        legal  = 1'b1;
        arg_op = 1'b0;
        case (cur_op)
            OP_NOP, OP_EXIT: ;
            OP_DOLIT:  begin push_d = 1'b1; arg_op = 1'b1; end
            OP_BRAN:   arg_op = 1'b1;
            OP_ZBRAN:  begin need_d = 2'd1; arg_op = 1'b1; end
            OP_DONEXT: begin need_r = 1'b1; arg_op = 1'b1; end
            OP_TOR:    begin need_d = 2'd1; push_r = 1'b1; end
            OP_FROMR:  begin need_r = 1'b1; push_d = 1'b1; end
            OP_DUP:    begin need_d = 2'd1; push_d = 1'b1; end
            OP_OVER:   begin need_d = 2'd2; push_d = 1'b1; end
            OP_DROP, OP_ZEQ, OP_ZLT, OP_NEG: need_d = 2'd1;
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: need_d = 2'd2;
            default:   legal = 1'b0;
        endcase
        if (!legal)
            fault = 2'd3;
        else if ((sp < SPW'(need_d)) || (need_r && rsp == '0))
            fault = 2'd2;
        else if ((push_d && sp == SP_FULL) || (push_r && rsp == RP_FULL))
            fault = 2'd1;
        else
            fault = 2'd0;
    end

    assign apply = ((state == S_EXEC) && (fault == 2'd0) && !arg_op &&
                    !(cur_op == OP_EXIT && rsp == '0)) ||
                   ((state == S_ARG) && last);

    always_comb begin
        sp_n  = sp;
        rsp_n = rsp;
        ip_n  = ip + IP1;
        dwe_a = 1'b0; dwa_a = di_top; dwd_a = tos_v;
        dwe_b = 1'b0; dwa_b = di_s0;  dwd_b = tos_v;
        rwe   = 1'b0; rwa   = ri_new; rwd   = tos_v;
        case (cur_op)
            OP_DOLIT: begin
                dwe_a = 1'b1; dwa_a = di_new; dwd_a = arg_full[DSZ-1:0];
                sp_n = sp + SP1; ip_n = ip + IP_LIT;
            end
            OP_BRAN:  ip_n = arg_ip;
            OP_ZBRAN: begin
                sp_n = sp - SP1;
                ip_n = (tos_v == '0) ? arg_ip : ip + IP_BR;
            end
            OP_DONEXT: begin
                if (rtop == '0) begin
                    rsp_n = rsp - RP1; ip_n = ip + IP_BR;
                end else begin
                    rwe = 1'b1; rwa = ri_top; rwd = rtop - D_ONE; ip_n = arg_ip;
                end
            end
            OP_TOR:   begin sp_n = sp - SP1; rwe = 1'b1; rsp_n = rsp + RP1; end
            OP_FROMR: begin
                dwe_a = 1'b1; dwa_a = di_new; dwd_a = rtop;
                sp_n = sp + SP1; rsp_n = rsp - RP1;
            end
            OP_DUP:   begin dwe_a = 1'b1; dwa_a = di_new; sp_n = sp + SP1; end
            OP_DROP:  sp_n = sp - SP1;
            OP_OVER:  begin dwe_a = 1'b1; dwa_a = di_new; dwd_a = s0; sp_n = sp + SP1; end
            OP_SWAP:  begin dwe_a = 1'b1; dwd_a = s0; dwe_b = 1'b1; end
            OP_ADD:   begin dwe_a = 1'b1; dwa_a = di_s0; dwd_a = s0 + tos_v; sp_n = sp - SP1; end
            OP_SUB:   begin dwe_a = 1'b1; dwa_a = di_s0; dwd_a = s0 - tos_v; sp_n = sp - SP1; end
            OP_AND:   begin dwe_a = 1'b1; dwa_a = di_s0; dwd_a = s0 & tos_v; sp_n = sp - SP1; end
            OP_OR:    begin dwe_a = 1'b1; dwa_a = di_s0; dwd_a = s0 | tos_v; sp_n = sp - SP1; end
            OP_XOR:   begin dwe_a = 1'b1; dwa_a = di_s0; dwd_a = s0 ^ tos_v; sp_n = sp - SP1; end
            OP_ZEQ:   begin dwe_a = 1'b1; dwd_a = {DSZ{tos_v == '0}}; end
            OP_ZLT:   begin dwe_a = 1'b1; dwd_a = {DSZ{tos_v[DSZ-1]}}; end
            OP_NEG:   begin dwe_a = 1'b1; dwd_a = ~tos_v + D_ONE; end
            OP_EXIT:  begin rsp_n = rsp - RP1; ip_n = rtop_ip; end
            default: ;
        endcase
    end

    always_comb begin
        state_n  = state;
        mem_addr = '0;
        mem_re   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (en) state_n = S_FETCH;
            S_FETCH: begin
                mem_addr = ip;
                mem_re   = 1'b1;
                state_n  = S_EXEC;
            end
            S_EXEC: begin
                if (fault != 2'd0)
                    state_n = S_ERR;
                else if (arg_op) begin
                    mem_addr = ip + IP1;
                    mem_re   = 1'b1;
                    state_n  = S_ARG;
                end else if (cur_op == OP_EXIT && rsp == '0)
                    state_n = S_DONE;
                else
                    state_n = S_FETCH;
            end
            S_ARG: begin
                if (last)
                    state_n = S_FETCH;
                else begin
                    mem_addr = ip + ASZ'(cnt) + IP2;
                    mem_re   = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ip     <= '0;
            sp     <= '0;
            rsp    <= '0;
            op_r   <= '0;
            cnt    <= '0;
            arg_r  <= '0;
            code_r <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (en) begin
                        ip     <= pfa;
                        code_r <= '0;
                        rsp    <= '0;
                    end
                end
                S_EXEC: begin
                    if (fault != 2'd0)
                        code_r <= fault;
                    else if (arg_op) begin
                        op_r  <= cur_op;
                        cnt   <= '0;
                        arg_r <= '0;
                    end
                end
                S_ARG: begin
                    if (!last) begin
                        cnt   <= cnt + 4'd1;
                        arg_r <= arg_full;
                    end
                end
                default: ;
            endcase
            if (apply) begin
                ip  <= ip_n;
                sp  <= sp_n;
                rsp <= rsp_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (apply && dwe_a) dstk[dwa_a] <= dwd_a;
        if (apply && dwe_b) dstk[dwa_b] <= dwd_b;
        if (apply && rwe)   rstk[rwa]   <= rwd;
    end
endmodule

// File: tb/tb_eforth_inner_p.sv
// Bench for eforth_inner_p: directed programs plus random straight-line programs
// checked against a queue-based eForth interpreter model.
module tb_eforth_inner_p;
    localparam int DSZ    = 32;
    localparam int ASZ    = 17;
    localparam int DDEPTH = 4;
    localparam int RDEPTH = 4;
    localparam int SPW    = $clog2(DDEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, en;
    logic [ASZ-1:0]   pfa, mem_addr;
    logic             mem_re;
    logic [7:0]       mem_rdata;
    logic             bsy, done, err;
    logic [1:0]       err_code;
    logic [DSZ-1:0]   tos;
    logic [SPW-1:0]   sp;
    logic [2:0]       dbg_state;

    logic [7:0]       mem [0:(1<<ASZ)-1];
    logic [31:0]      exp_q [$];
    logic [31:0]      m_rs [$];
    logic [16:0]      wp;
    int               n_checks = 0;
    int               n_pass = 0;
    logic [7:0]       pool [0:15] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h07, 8'h08, 8'h09, 8'h0A,
                                      8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12};

    eforth_inner_p #(.DSZ(DSZ), .ASZ(ASZ), .DDEPTH(DDEPTH), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .pfa(pfa), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .bsy(bsy), .done(done), .err(err), .err_code(err_code),
        .tos(tos), .sp(sp), .dbg_state(dbg_state)
    );

    // clock / memory
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    // driver tasks
    task automatic emit(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 17'd1;
    endtask

    task automatic emit_lit(input logic [31:0] v);
        emit(8'h01); emit(v[7:0]); emit(v[15:8]); emit(v[23:16]); emit(v[31:24]);
    endtask

    task automatic emit_addr(input logic [16:0] a);
        emit(a[7:0]); emit(a[15:8]); emit({7'd0, a[16]});
    endtask

    task automatic do_reset;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_dut(input logic [16:0] start, output int cyc, output bit tmo, output bit b0);
        @(negedge clk); pfa = start; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        b0 = bsy;
        cyc = 0; tmo = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1; cyc++;
            if (done || err) begin tmo = 1'b0; break; end
        end
    endtask

    // reference interpreter: stacks as queues, cycle cost per opcode class
    task automatic model_run(input logic [16:0] start, output int cyc, output bit m_ok,
                             output logic [1:0] m_code);
        logic [16:0] ip, t;
        logic [23:0] t24;
        logic [7:0]  op;
        logic [31:0] a, b, v;
        int nd;
        bit fin;
        ip = start; cyc = 0; m_ok = 1'b0; m_code = 2'd0; fin = 1'b0;
        m_rs.delete();
        for (int step = 0; step < 4000 && !fin; step++) begin
            op  = mem[ip];
            nd  = exp_q.size();
            t24 = {mem[ip + 17'd3], mem[ip + 17'd2], mem[ip + 17'd1]};
            t   = t24[16:0];
            case (op)
                8'h00: begin ip = ip + 17'd1; cyc += 2; end
                8'h01: if (nd == DDEPTH) m_code = 2'd1;
                       else begin
                           exp_q.push_back({mem[ip + 17'd4], mem[ip + 17'd3], mem[ip + 17'd2], mem[ip + 17'd1]});
                           ip = ip + 17'd5; cyc += 6;
                       end
                8'h02: begin ip = t; cyc += 5; end
                8'h03: if (nd < 1) m_code = 2'd2;
                       else begin a = exp_q.pop_back(); ip = (a == 0) ? t : ip + 17'd4; cyc += 5; end
                8'h04: if (m_rs.size() == 0) m_code = 2'd2;
                       else begin
                           v = m_rs.pop_back();
                           if (v == 0) ip = ip + 17'd4;
                           else begin m_rs.push_back(v - 32'd1); ip = t; end
                           cyc += 5;
                       end
                8'h05: if (nd < 1) m_code = 2'd2;
                       else if (m_rs.size() == RDEPTH) m_code = 2'd1;
                       else begin m_rs.push_back(exp_q.pop_back()); ip = ip + 17'd1; cyc += 2; end
                8'h06: if (m_rs.size() == 0) m_code = 2'd2;
                       else if (nd == DDEPTH) m_code = 2'd1;
                       else begin exp_q.push_back(m_rs.pop_back()); ip = ip + 17'd1; cyc += 2; end
                8'h07, 8'h09: if (nd < ((op == 8'h07) ? 1 : 2)) m_code = 2'd2;
                       else if (nd == DDEPTH) m_code = 2'd1;
                       else begin
                           v = (op == 8'h07) ? exp_q[nd-1] : exp_q[nd-2];
                           exp_q.push_back(v); ip = ip + 17'd1; cyc += 2;
                       end
                8'h08: if (nd < 1) m_code = 2'd2;
                       else begin void'(exp_q.pop_back()); ip = ip + 17'd1; cyc += 2; end
                8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F:
                       if (nd < 2) m_code = 2'd2;
                       else begin
                           b = exp_q.pop_back(); a = exp_q.pop_back();
                           case (op)
                               8'h0A: begin exp_q.push_back(b); v = a; end
                               8'h0B: v = a + b;
                               8'h0C: v = a - b;
                               8'h0D: v = a & b;
                               8'h0E: v = a | b;
                               default: v = a ^ b;
                           endcase
                           exp_q.push_back(v); ip = ip + 17'd1; cyc += 2;
                       end
                8'h10, 8'h11, 8'h12:
                       if (nd < 1) m_code = 2'd2;
                       else begin
                           a = exp_q.pop_back();
                           if (op == 8'h10) v = (a == 0) ? 32'hFFFF_FFFF : 32'd0;
                           else if (op == 8'h11) v = a[31] ? 32'hFFFF_FFFF : 32'd0;
                           else v = 32'd0 - a;
                           exp_q.push_back(v); ip = ip + 17'd1; cyc += 2;
                       end
                8'h13: begin
                    cyc += 2;
                    if (m_rs.size() == 0) begin m_ok = 1'b1; fin = 1'b1; end
                    else begin v = m_rs.pop_back(); ip = v[16:0]; end
                end
                default: m_code = 2'd3;
            endcase
            if (m_code != 2'd0) begin cyc += 2; fin = 1'b1; end
        end
    endtask

    // scenarios
    task automatic test_reset;
        rst = 1'b1; en = 1'b0; pfa = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bsy !== 1'b0) $display("FAIL reset_bsy got %b exp 0", bsy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
        n_checks++; if (mem_re !== 1'b0) $display("FAIL reset_mem_re got %b exp 0", mem_re); else n_pass++;
        n_checks++; if (err_code !== 2'd0) $display("FAIL reset_err_code got %0d exp 0", err_code); else n_pass++;
        n_checks++; if (mem_addr !== 17'd0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else n_pass++;
        n_checks++; if (sp !== 3'd0) $display("FAIL reset_sp got %0d exp 0", sp); else n_pass++;
        n_checks++; if (tos !== 32'd0) $display("FAIL reset_tos got %h exp 0", tos); else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add;
        int cyc; bit tmo, b0;
        wp = 17'h100; emit_lit(32'd5); emit_lit(32'd3); emit(8'h0B); emit(8'h13);
        run_dut(17'h100, cyc, tmo, b0);
        n_checks++; if (tmo) $display("FAIL add_timeout no done/err within bound"); else n_pass++;
        n_checks++; if (b0 !== 1'b1) $display("FAIL add_bsy_start got %b exp 1", b0); else n_pass++;
        n_checks++; if (cyc != 16) $display("FAIL add_cycles got %0d exp 16", cyc); else n_pass++;
        n_checks++; if (done !== 1'b1 || err !== 1'b0 || bsy !== 1'b0)
            $display("FAIL add_flags got done=%b err=%b bsy=%b exp 1 0 0", done, err, bsy); else n_pass++;
        n_checks++; if (tos !== 32'd8) $display("FAIL add_tos got %0d exp 8", tos); else n_pass++;
        n_checks++; if (sp !== 3'd1) $display("FAIL add_sp got %0d exp 1", sp); else n_pass++;
    endtask

    task automatic test_rerun;
        int cyc; bit tmo, b0;
        wp = 17'h200; emit(8'h07); emit(8'h0B); emit(8'h13);
        run_dut(17'h200, cyc, tmo, b0);
        n_checks++; if (tmo || cyc != 6) $display("FAIL rerun_cycles got %0d exp 6", cyc); else n_pass++;
        n_checks++; if (tos !== 32'd16) $display("FAIL rerun_tos got %0d exp 16", tos); else n_pass++;
        n_checks++; if (sp !== 3'd1) $display("FAIL rerun_sp got %0d exp 1", sp); else n_pass++;
    endtask

    task automatic test_loop;
        int cyc; bit tmo, b0;
        do_reset();
        wp = 17'h300; emit_lit(32'd3); emit(8'h05); emit(8'h04); emit_addr(17'h306); emit(8'h13);
        run_dut(17'h300, cyc, tmo, b0);
        // DOLIT 6 + >R 2 + four DONEXT passes of 5 + EXIT 2
        n_checks++; if (tmo || cyc != 30) $display("FAIL loop_cycles got %0d exp 30", cyc); else n_pass++;
        n_checks++; if (done !== 1'b1 || err !== 1'b0)
            $display("FAIL loop_done got done=%b err=%b exp 1 0", done, err); else n_pass++;
        n_checks++; if (sp !== 3'd0) $display("FAIL loop_sp got %0d exp 0", sp); else n_pass++;
        n_checks++; if (tos !== 32'd0) $display("FAIL loop_tos got %h exp 0", tos); else n_pass++;
    endtask

    task automatic test_zbran;
        int cyc; bit tmo, b0;
        logic [16:0] base;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            base = (pass == 0) ? 17'h400 : 17'h500;
            wp = base;
            emit_lit((pass == 0) ? 32'd0 : 32'd7);
            emit(8'h03); emit_addr(base + 17'h0F);
            emit_lit(32'h11); emit(8'h13);
            emit_lit(32'h22); emit(8'h13);
            run_dut(base, cyc, tmo, b0);
            n_checks++; if (tmo || cyc != 19) $display("FAIL zbran%0d_cycles got %0d exp 19", pass, cyc); else n_pass++;
            n_checks++; if (done !== 1'b1) $display("FAIL zbran%0d_done got %b exp 1", pass, done); else n_pass++;
            n_checks++; if (tos !== ((pass == 0) ? 32'h22 : 32'h11))
                $display("FAIL zbran%0d_tos got %h exp %h", pass, tos, (pass == 0) ? 32'h22 : 32'h11); else n_pass++;
            n_checks++; if (sp !== 3'd1) $display("FAIL zbran%0d_sp got %0d exp 1", pass, sp); else n_pass++;
        end
    endtask

    task automatic test_faults;
        int cyc; bit tmo, b0;
        do_reset();
        wp = 17'h700;
        for (int k = 1; k <= 5; k++) emit_lit(32'(k * 10));
        emit(8'h13);
        run_dut(17'h700, cyc, tmo, b0);
        n_checks++; if (tmo || cyc != 26) $display("FAIL ovf_cycles got %0d exp 26", cyc); else n_pass++;
        n_checks++; if (err !== 1'b1 || done !== 1'b0 || bsy !== 1'b0)
            $display("FAIL ovf_flags got err=%b done=%b bsy=%b exp 1 0 0", err, done, bsy); else n_pass++;
        n_checks++; if (err_code !== 2'd1) $display("FAIL ovf_code got %0d exp 1", err_code); else n_pass++;
        n_checks++; if (sp !== 3'd4) $display("FAIL ovf_sp got %0d exp 4", sp); else n_pass++;
        n_checks++; if (tos !== 32'd40) $display("FAIL ovf_tos got %0d exp 40", tos); else n_pass++;

        do_reset();
        wp = 17'h780; emit(8'h08);
        run_dut(17'h780, cyc, tmo, b0);
        n_checks++; if (tmo || cyc != 2) $display("FAIL unf_cycles got %0d exp 2", cyc); else n_pass++;
        n_checks++; if (err !== 1'b1 || err_code !== 2'd2)
            $display("FAIL unf_drop got err=%b code=%0d exp 1 2", err, err_code); else n_pass++;
        wp = 17'h790; emit(8'h06);
        run_dut(17'h790, cyc, tmo, b0);
        n_checks++; if (tmo || err !== 1'b1 || err_code !== 2'd2)
            $display("FAIL unf_fromr got err=%b code=%0d exp 1 2", err, err_code); else n_pass++;

        wp = 17'h7A0; emit(8'hFF);
        run_dut(17'h7A0, cyc, tmo, b0);
        n_checks++; if (tmo || err !== 1'b1 || err_code !== 2'd3)
            $display("FAIL illegal got err=%b code=%0d exp 1 3", err, err_code); else n_pass++;
        n_checks++; if (sp !== 3'd0) $display("FAIL illegal_sp got %0d exp 0", sp); else n_pass++;

        wp = 17'h7B0; emit(8'h13);
        run_dut(17'h7B0, cyc, tmo, b0);
        n_checks++; if (tmo || done !== 1'b1 || err !== 1'b0 || err_code !== 2'd0)
            $display("FAIL restart_clear got done=%b err=%b code=%0d exp 1 0 0", done, err, err_code); else n_pass++;
    endtask

    task automatic test_rst_mid;
        int cyc; bit tmo, b0;
        do_reset();
        wp = 17'h600; emit_lit(32'd1); emit_lit(32'd2); emit(8'h13);
        run_dut(17'h600, cyc, tmo, b0);
        n_checks++; if (tmo || sp !== 3'd2) $display("FAIL rstmid_pre_sp got %0d exp 2", sp); else n_pass++;
        @(negedge clk); pfa = 17'h600; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (bsy !== 1'b1 || mem_re !== 1'b1)
            $display("FAIL rstmid_in_arg got bsy=%b mem_re=%b exp 1 1", bsy, mem_re); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bsy !== 1'b0) $display("FAIL rstmid_bsy got %b exp 0", bsy); else n_pass++;
        n_checks++; if (sp !== 3'd0) $display("FAIL rstmid_sp got %0d exp 0", sp); else n_pass++;
        n_checks++; if (mem_re !== 1'b0) $display("FAIL rstmid_mem_re got %b exp 0", mem_re); else n_pass++;
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_random;
        int cyc, m_cyc, n, r;
        bit tmo, b0, m_ok;
        logic [1:0] m_code;
        logic [16:0] base;
        logic [7:0] op;
        logic [31:0] lv, etos;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) do_reset();
            base = 17'h1000 + 17'(i * 128);
            wp = base;
            n = $urandom_range(4, 14);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 99);
                if (r < 3) emit(8'($urandom_range(8'h14, 8'hFF)));
                else if (r < 6) emit(8'h06);
                else begin
                    op = pool[$urandom_range(0, 15)];
                    lv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
                    if (op == 8'h01) emit_lit(lv); else emit(op);
                end
            end
            emit(8'h13);
            model_run(base, m_cyc, m_ok, m_code);
            run_dut(base, cyc, tmo, b0);
            etos = (exp_q.size() > 0) ? exp_q[$] : 32'd0;
            n_checks++; if (tmo) $display("FAIL rnd%0d_timeout no done/err within bound", i); else n_pass++;
            n_checks++; if (done !== m_ok) $display("FAIL rnd%0d_done got %b exp %b", i, done, m_ok); else n_pass++;
            n_checks++; if (err !== !m_ok) $display("FAIL rnd%0d_err got %b exp %b", i, err, !m_ok); else n_pass++;
            n_checks++; if (err_code !== m_code) $display("FAIL rnd%0d_code got %0d exp %0d", i, err_code, m_code); else n_pass++;
            n_checks++; if (sp !== 3'(exp_q.size())) $display("FAIL rnd%0d_sp got %0d exp %0d", i, sp, exp_q.size()); else n_pass++;
            n_checks++; if (tos !== etos) $display("FAIL rnd%0d_tos got %h exp %h", i, tos, etos); else n_pass++;
            n_checks++; if (cyc != m_cyc) $display("FAIL rnd%0d_cycles got %0d exp %0d", i, cyc, m_cyc); else n_pass++;
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << ASZ); a++) mem[a] = 8'h00;
        test_reset();
        test_add();
        test_rerun();
        test_loop();
        test_zbran();
        test_faults();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
